// File: rtl/mario_snd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mario_snd_pkg
// Brief    : Shared types and width helpers for the TDM sound mixer.
// Revision : 1.0 - initial release
// ============================================================================
package mario_snd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        SCALE = 2'd2,
        SAT   = 2'd3
    } snd_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Wide enough that NUM_CH full-scale products can never overflow.
    function automatic int acc_w(input int in_w, input int gain_w, input int num_ch);
        return in_w + gain_w + clog2(num_ch) + 1;
    endfunction

    function automatic int unity_gain(input int gain_w);
        return 1 << (gain_w - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mario_snd_sat.sv
`default_nettype none
// ============================================================================
// Module   : mario_snd_sat
// Brief    : Signed clamp from IN_W to OUT_W bits with a clip flag.
// Revision : 1.0 - initial release
// ============================================================================
module mario_snd_sat #(
    parameter int IN_W  = 22,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  i_dat,
    output logic signed [OUT_W-1:0] o_dat,
    output logic                    o_clip
);

    generate
        if (IN_W > OUT_W) begin : g_clamp
            localparam logic signed [IN_W-1:0] c_MAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
            localparam logic signed [IN_W-1:0] c_MIN = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
            logic w_hi;
            logic w_lo;

            assign w_hi   = (i_dat > c_MAX);
            assign w_lo   = (i_dat < c_MIN);
            assign o_clip = w_hi | w_lo;
            assign o_dat  = w_hi ? c_MAX[OUT_W-1:0] :
                            w_lo ? c_MIN[OUT_W-1:0] : i_dat[OUT_W-1:0];
        end else begin : g_pass
            assign o_clip = 1'b0;
            assign o_dat  = OUT_W'(i_dat);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mario_sound_mixer_tdm.sv
`default_nettype none
// ============================================================================
// Module   : mario_sound_mixer_tdm
// Brief    : Time-multiplexed N-channel mixer: per-channel gain, master fade
//            ramp and output saturation over one shared multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module mario_sound_mixer_tdm
    import mario_snd_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IN_W   = 16,
    parameter int GAIN_W = 8,
    parameter int RAMP_W = 4,
    parameter int OUT_W  = 16
) (
    input  logic                     I_CLK_48M,
    input  logic                     I_RST,
    input  logic                     I_SAMPLE_CEN,
    input  logic [NUM_CH*IN_W-1:0]   I_SND_DAT,
    input  logic [NUM_CH-1:0]        I_CH_SIGNED,
    input  logic [NUM_CH*GAIN_W-1:0] I_GAIN,
    input  logic                     I_MUTE,
    output logic [OUT_W-1:0]         O_SND_DAT,
    output logic                     O_SND_VLD,
    output logic                     O_CLIP,
    output logic                     O_OVERRUN,
    output logic                     O_BUSY
);

    localparam int c_ACC_W  = acc_w(IN_W, GAIN_W, NUM_CH);
    localparam int c_CNT_W  = (clog2(NUM_CH) > 0) ? clog2(NUM_CH) : 1;
    localparam int c_PROD_W = IN_W + GAIN_W + 1;
    localparam int c_SH_W   = c_ACC_W - (GAIN_W - 1);
    localparam int c_MUL_W  = c_SH_W + RAMP_W + 2;
    localparam int c_MIX_W  = c_MUL_W - RAMP_W;
    localparam logic [c_CNT_W-1:0] c_LAST_CH  = c_CNT_W'(NUM_CH - 1);
    localparam logic [RAMP_W:0]    c_RAMP_MAX = (RAMP_W + 1)'(1 << RAMP_W);

    snd_state_t                  r_state;
    logic [c_CNT_W-1:0]          r_cnt;
    logic [NUM_CH*IN_W-1:0]      r_dat;
    logic [NUM_CH-1:0]           r_signed;
    logic [NUM_CH*GAIN_W-1:0]    r_gain;
    logic signed [c_ACC_W-1:0]   r_acc;
    logic [RAMP_W:0]             r_ramp;
    logic signed [c_MIX_W-1:0]   r_mix;
    logic [OUT_W-1:0]            r_out;
    logic                        r_vld;
    logic                        r_clip;
    logic                        r_ovr;
    logic                        r_busy;

    logic signed [IN_W-1:0]      w_conv;
    logic signed [c_PROD_W-1:0]  w_prod;
    logic signed [c_SH_W-1:0]    w_shift;
    logic signed [c_MUL_W-1:0]   w_mul;
    logic signed [c_MIX_W-1:0]   w_mix;
    logic signed [OUT_W-1:0]     w_sat;
    logic                        w_clip;

    // Snapshot registers shift down one channel per ACC cycle, so the
    // current channel always sits in the low slice.
    assign w_conv  = {r_signed[0] ? r_dat[IN_W-1] : ~r_dat[IN_W-1], r_dat[IN_W-2:0]};
    assign w_prod  = c_PROD_W'(w_conv) * c_PROD_W'($signed({1'b0, r_gain[GAIN_W-1:0]}));
    assign w_shift = c_SH_W'(r_acc >>> (GAIN_W - 1));
    assign w_mul   = c_MUL_W'(w_shift) * c_MUL_W'($signed({1'b0, r_ramp}));
    assign w_mix   = c_MIX_W'(w_mul >>> RAMP_W);

    mario_snd_sat #(
        .IN_W  (c_MIX_W),
        .OUT_W (OUT_W)
    ) u_sat (
        .i_dat  (r_mix),
        .o_dat  (w_sat),
        .o_clip (w_clip)
    );

    always_ff @(posedge I_CLK_48M) begin
        if (I_RST) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_dat    <= '0;
            r_signed <= '0;
            r_gain   <= '0;
            r_acc    <= '0;
            r_ramp   <= '0;
            r_mix    <= '0;
            r_out    <= '0;
            r_vld    <= 1'b0;
            r_clip   <= 1'b0;
            r_ovr    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            if (I_SAMPLE_CEN && (r_state != IDLE)) r_ovr <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (I_SAMPLE_CEN) begin
                        r_dat    <= I_SND_DAT;
                        r_signed <= I_CH_SIGNED;
                        r_gain   <= I_GAIN;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ACC;
                    end
                end
                ACC: begin
                    r_acc    <= r_acc + c_ACC_W'(w_prod);
                    r_dat    <= r_dat >> IN_W;
                    r_signed <= r_signed >> 1;
                    r_gain   <= r_gain >> GAIN_W;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST_CH) r_state <= SCALE;
                end
                SCALE: begin
                    r_mix <= w_mix;
                    if (I_MUTE) begin
                        if (r_ramp != '0) r_ramp <= r_ramp - 1'b1;
                    end else begin
                        if (r_ramp != c_RAMP_MAX) r_ramp <= r_ramp + 1'b1;
                    end
                    r_state <= SAT;
                end
                SAT: begin
                    r_out   <= w_sat;
                    r_clip  <= w_clip;
                    r_vld   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign O_SND_DAT = r_out;
    assign O_SND_VLD = r_vld;
    assign O_CLIP    = r_clip;
    assign O_OVERRUN = r_ovr;
    assign O_BUSY    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mario_sound_mixer_tdm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mario_sound_mixer_tdm
// Brief    : Scoreboard bench for the TDM mixer with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mario_sound_mixer_tdm;

    localparam int c_PERIOD = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b0;
    logic [63:0] snd = '0;
    logic [3:0]  chs = 4'hF;
    logic [31:0] gain = {4{8'd128}};
    logic        mute = 1'b0;
    logic [15:0] o_dat;
    logic        o_vld;
    logic        o_clip;
    logic        o_ovr;
    logic        o_busy;

    typedef struct {
        int dat;
        bit clip;
        int at;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   tb_ramp = 0;

    mario_sound_mixer_tdm dut (
        .I_CLK_48M    (clk),
        .I_RST        (rst),
        .I_SAMPLE_CEN (cen),
        .I_SND_DAT    (snd),
        .I_CH_SIGNED  (chs),
        .I_GAIN       (gain),
        .I_MUTE       (mute),
        .O_SND_DAT    (o_dat),
        .O_SND_VLD    (o_vld),
        .O_CLIP       (o_clip),
        .O_OVERRUN    (o_ovr),
        .O_BUSY       (o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (o_vld) begin
            if (q.size() == 0) begin
                check("unexpected_vld", 1, 0);
            end else begin
                mon_e = q.pop_front();
                check("snd_dat", int'($signed(o_dat)), mon_e.dat);
                check("clip", int'(o_clip), int'(mon_e.clip));
                check("vld_latency", cyc, mon_e.at);
            end
        end
    end

    task automatic step_ramp();
        if (mute) tb_ramp = (tb_ramp > 0) ? tb_ramp - 1 : 0;
        else      tb_ramp = (tb_ramp < 16) ? tb_ramp + 1 : 16;
    endtask

    // One strobe; VLD is due on the 7th rising edge counting the sampling edge.
    task automatic mix(input int exp_dat, input bit exp_clip);
        @(negedge clk);
        cen = 1'b1;
        q.push_back('{exp_dat, exp_clip, cyc + 7});
        @(negedge clk);
        cen = 1'b0;
        step_ramp();
        repeat (c_PERIOD - 2) @(negedge clk);
    endtask

    task automatic set_all(input logic [15:0] v);
        snd = {4{v}};
    endtask

    initial begin
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_dat", int'(o_dat), 0);
        check("rst_vld", int'(o_vld), 0);
        check("rst_clip", int'(o_clip), 0);
        check("rst_overrun", int'(o_ovr), 0);
        check("rst_busy", int'(o_busy), 0);

        // Fade-in: 4 x 1000 at unity gain = 4000 at full ramp
        set_all(16'd1000);
        for (int i = 0; i < 18; i++) mix(250 * tb_ramp, 1'b0);

        // Saturation at full ramp
        set_all(16'd30000);
        gain = {8'd128, 8'd128, 8'd128, 8'd255};
        mix(32767, 1'b1);
        set_all(-16'sd30000);
        mix(-32768, 1'b1);

        // Offset binary on ch3 only
        gain = {4{8'd128}};
        chs  = 4'b0111;
        snd  = {16'h8000, 48'h0};
        mix(0, 1'b0);
        snd  = {16'hFFFF, 48'h0};
        mix(32767, 1'b0);
        snd  = {16'h0000, 48'h0};
        mix(-32768, 1'b0);

        // Mute ramp down and back up
        chs = 4'hF;
        set_all(16'd1000);
        mix(4000, 1'b0);
        mute = 1'b1;
        for (int i = 0; i < 18; i++) mix(250 * tb_ramp, 1'b0);
        mute = 1'b0;
        for (int i = 0; i < 18; i++) mix(250 * tb_ramp, 1'b0);

        // Overrun: second strobe 3 cycles after the first is dropped
        check("ovr_before", int'(o_ovr), 0);
        @(negedge clk);
        cen = 1'b1;
        q.push_back('{250 * tb_ramp, 1'b0, cyc + 7});
        @(negedge clk);
        cen = 1'b0;
        step_ramp();
        check("busy_in_acc", int'(o_busy), 1);
        repeat (2) @(negedge clk);
        cen = 1'b1;
        @(negedge clk);
        cen = 1'b0;
        repeat (c_PERIOD) @(negedge clk);
        check("ovr_set", int'(o_ovr), 1);
        check("busy_idle", int'(o_busy), 0);
        mix(250 * tb_ramp, 1'b0);
        check("ovr_sticky", int'(o_ovr), 1);

        // Reset mid-mix abandons the sample and restarts the fade
        @(negedge clk);
        cen = 1'b1;
        @(negedge clk);
        cen = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tb_ramp = 0;
        repeat (20) @(negedge clk);
        check("midrst_dat", int'(o_dat), 0);
        check("midrst_overrun", int'(o_ovr), 0);
        check("midrst_busy", int'(o_busy), 0);
        mix(0, 1'b0);
        mix(250, 1'b0);

        repeat (20) @(negedge clk);
        check("pending_expectations", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
